// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit definitions: FSM encoding, datapath widths and the default reset PC.
package fetch_unit_pkg;

    localparam int INS_W  = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally from the read pointer.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, response FIFO, redirect flush and drain.
//  state   | meaning
//  S_RUN   | issuing requests, pushing responses into the FIFO
//  S_DRAIN | requests held off, dropping responses issued before a redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

    state_t                    state;
    state_t                    state_next;
    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         pc_next;
    logic [CW-1:0]             outstanding;
    logic [CW-1:0]             out_next;
    logic [CW-1:0]             discard;
    logic [CW-1:0]             disc_next;
    logic [CW-1:0]             fifo_count;
    logic [CW-1:0]             in_transit;
    logic [CW:0]               in_flight;
    logic                      run_en;
    logic                      issue;
    logic                      push;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [ADDR_W-1:0]         resp_pc;
    logic [INS_W+ADDR_W-1:0]   head;

    // run_en delays the first request by one cycle after reset is released.
    assign in_flight  = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req   = run_en && (state == S_RUN) && (in_flight < CREDITS) && !fifo_full;
    assign imem_addr  = pc;
    assign issue      = imem_req && imem_gnt;
    assign push       = imem_rvalid && (state == S_RUN) && !redirect;
    assign in_transit = outstanding + CW'(issue) - CW'(imem_rvalid);
    // Responses are in order, so the oldest outstanding request sits that many words behind pc.
    assign resp_pc    = pc - (ADDR_W'(outstanding) << 2);
    assign ins_valid  = !fifo_empty;
    assign ins        = head[INS_W+ADDR_W-1:ADDR_W];
    assign ins_pc     = head[ADDR_W-1:0];

    always_comb begin
        state_next = state;
        pc_next    = pc;
        out_next   = outstanding;
        disc_next  = discard;
        if (state == S_RUN) begin
            out_next = in_transit;
            if (issue) begin
                pc_next = pc + ADDR_W'(4);
            end
        end else if (imem_rvalid) begin
            disc_next = discard - CW'(1);
            if (discard == CW'(1)) begin
                state_next = S_RUN;
            end
        end
        if (redirect) begin
            pc_next = redirect_pc & ~ADDR_W'(3);
            if (state == S_RUN) begin
                out_next   = '0;
                disc_next  = in_transit;
                state_next = (in_transit != '0) ? S_DRAIN : S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_RUN;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            run_en      <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            outstanding <= out_next;
            discard     <= disc_next;
            run_en      <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (INS_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (ins_ready),
        .flush (redirect),
        .din   ({imem_rdata, resp_pc}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem responder model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    bit          rv_en = 1'b0;
    logic [31:0] q[$];
    int          n_pass = 0;
    int          n_total = 0;

    typedef struct {
        bit          do_rst;
        bit          gnt;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [16];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Called at a falling edge with inputs already set; advances one cycle.
    task automatic step();
        bit          iss;
        bit          rv;
        bit          rst_s;
        logic [31:0] iss_addr;
        if (rv_en && q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(q[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        iss      = imem_req && imem_gnt;
        iss_addr = imem_addr;
        rv       = imem_rvalid;
        rst_s    = rst;
        if (ins_valid && ins_ready) chk("ins_data", ins, word(ins_pc));
        @(posedge clk);
        @(negedge clk);
        if (!rst_s) begin
            q.delete();
        end else begin
            if (rv) void'(q.pop_front());
            if (iss) q.push_back(iss_addr);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req"},    {31'd0, imem_req},  32'd0);
        chk({nm, "_valid"},  {31'd0, ins_valid}, 32'd0);
        chk({nm, "_addr"},   imem_addr,          32'h0);
        chk({nm, "_ins"},    ins,                32'h0);
        chk({nm, "_ins_pc"}, ins_pc,             32'h0);
    endtask

    // Leaves the bench at the falling edge of the first cycle after reset release.
    task automatic do_reset();
        rst = 1'b0; imem_gnt = 1'b0; ins_ready = 1'b0; redirect = 1'b0; rv_en = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b1;
        step();
    endtask

    task automatic next_fire(input string nm, input logic [31:0] exp_pc);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (ins_valid && ins_ready) begin
                chk(nm, ins_pc, exp_pc);
                got = 1'b1;
            end
            step();
        end
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: streaming, ready high. Test 2: ready low fills credits, then one issue per pop.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd4};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16};

        @(negedge clk);
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            imem_gnt  = vecs[i].gnt;
            ins_ready = vecs[i].ready;
            rv_en     = 1'b1;
            chk($sformatf("v%0d_req", i),   {31'd0, imem_req},  {31'd0, vecs[i].exp_req});
            chk($sformatf("v%0d_addr", i),  imem_addr,          vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, ins_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) chk($sformatf("v%0d_pc", i), ins_pc, vecs[i].exp_pc);
            step();
        end

        // Test 3: grant withheld, request and address must hold.
        do_reset();
        imem_gnt = 1'b0; ins_ready = 1'b1; rv_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_hold_req%0d", i),  {31'd0, imem_req}, 32'd1);
            chk($sformatf("t3_hold_addr%0d", i), imem_addr,         32'd0);
            step();
        end
        imem_gnt = 1'b1;
        step();
        chk("t3_addr_after_gnt", imem_addr, 32'd4);
        next_fire("t3_first_pc", 32'd0);

        // Test 4: redirect with a buffered word and two requests outstanding.
        do_reset();
        imem_gnt = 1'b1; ins_ready = 1'b0; rv_en = 1'b1;
        step();
        step();
        rv_en = 1'b0;
        step();
        chk("t4_pre_valid", {31'd0, ins_valid}, 32'd1);
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        chk("t4_flushed_valid", {31'd0, ins_valid}, 32'd0);
        chk("t4_drain_req0",    {31'd0, imem_req},  32'd0);
        rv_en = 1'b1;
        step();
        chk("t4_drain_req1",    {31'd0, imem_req},  32'd0);
        chk("t4_drain_valid",   {31'd0, ins_valid}, 32'd0);
        step();
        chk("t4_resume_req",    {31'd0, imem_req},  32'd1);
        chk("t4_resume_addr",   imem_addr,          32'h0000_0100);
        imem_gnt = 1'b1; ins_ready = 1'b1;
        next_fire("t4_first_pc", 32'h0000_0100);
        next_fire("t4_second_pc", 32'h0000_0104);

        // Test 5: redirect coincides with an issue and a response.
        do_reset();
        imem_gnt = 1'b1; ins_ready = 1'b0; rv_en = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        chk("t5_drain_req",   {31'd0, imem_req},  32'd0);
        chk("t5_drain_valid", {31'd0, ins_valid}, 32'd0);
        step();
        chk("t5_resume_req",  {31'd0, imem_req},  32'd1);
        chk("t5_resume_addr", imem_addr,          32'h0000_0200);
        ins_ready = 1'b1;
        next_fire("t5_first_pc", 32'h0000_0200);
        next_fire("t5_second_pc", 32'h0000_0204);

        // Test 6: PC wrap, then reset in the middle of the stream.
        do_reset();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        chk("t6_addr", imem_addr, 32'hFFFF_FFF8);
        imem_gnt = 1'b1; ins_ready = 1'b1; rv_en = 1'b1;
        next_fire("t6_pc0", 32'hFFFF_FFF8);
        next_fire("t6_pc1", 32'hFFFF_FFFC);
        next_fire("t6_pc2", 32'h0000_0000);
        rst = 1'b0;
        step();
        chk_reset_outputs("t6_midrst");
        rst = 1'b1;
        step();
        next_fire("t6_restart_pc", 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
